// File: rtl/aes_pkg.sv
// Shared AES types, constant tables and GF(2^8) helpers for the inverse-cipher datapath.
// The forward S-box is kept because reverse key expansion still needs SubWord.
package aes_pkg;

   typedef logic [15:0][7:0] state_t;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_RUN,
      ST_DONE
   } fsm_t;

   // Index is the round number; entries outside 1..10 are never used.
   localparam logic [7:0] RCON [16] = '{
      8'h00, 8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40,
      8'h80, 8'h1b, 8'h36, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00
   };

   localparam logic [7:0] SBOX [256] = '{
      8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
      8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
      8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
      8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
      8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
      8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
      8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
      8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
      8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
      8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
      8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
      8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
      8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
      8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
      8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
      8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
   };

   localparam logic [7:0] INV_SBOX [256] = '{
      8'h52, 8'h09, 8'h6a, 8'hd5, 8'h30, 8'h36, 8'ha5, 8'h38, 8'hbf, 8'h40, 8'ha3, 8'h9e, 8'h81, 8'hf3, 8'hd7, 8'hfb,
      8'h7c, 8'he3, 8'h39, 8'h82, 8'h9b, 8'h2f, 8'hff, 8'h87, 8'h34, 8'h8e, 8'h43, 8'h44, 8'hc4, 8'hde, 8'he9, 8'hcb,
      8'h54, 8'h7b, 8'h94, 8'h32, 8'ha6, 8'hc2, 8'h23, 8'h3d, 8'hee, 8'h4c, 8'h95, 8'h0b, 8'h42, 8'hfa, 8'hc3, 8'h4e,
      8'h08, 8'h2e, 8'ha1, 8'h66, 8'h28, 8'hd9, 8'h24, 8'hb2, 8'h76, 8'h5b, 8'ha2, 8'h49, 8'h6d, 8'h8b, 8'hd1, 8'h25,
      8'h72, 8'hf8, 8'hf6, 8'h64, 8'h86, 8'h68, 8'h98, 8'h16, 8'hd4, 8'ha4, 8'h5c, 8'hcc, 8'h5d, 8'h65, 8'hb6, 8'h92,
      8'h6c, 8'h70, 8'h48, 8'h50, 8'hfd, 8'hed, 8'hb9, 8'hda, 8'h5e, 8'h15, 8'h46, 8'h57, 8'ha7, 8'h8d, 8'h9d, 8'h84,
      8'h90, 8'hd8, 8'hab, 8'h00, 8'h8c, 8'hbc, 8'hd3, 8'h0a, 8'hf7, 8'he4, 8'h58, 8'h05, 8'hb8, 8'hb3, 8'h45, 8'h06,
      8'hd0, 8'h2c, 8'h1e, 8'h8f, 8'hca, 8'h3f, 8'h0f, 8'h02, 8'hc1, 8'haf, 8'hbd, 8'h03, 8'h01, 8'h13, 8'h8a, 8'h6b,
      8'h3a, 8'h91, 8'h11, 8'h41, 8'h4f, 8'h67, 8'hdc, 8'hea, 8'h97, 8'hf2, 8'hcf, 8'hce, 8'hf0, 8'hb4, 8'he6, 8'h73,
      8'h96, 8'hac, 8'h74, 8'h22, 8'he7, 8'had, 8'h35, 8'h85, 8'he2, 8'hf9, 8'h37, 8'he8, 8'h1c, 8'h75, 8'hdf, 8'h6e,
      8'h47, 8'hf1, 8'h1a, 8'h71, 8'h1d, 8'h29, 8'hc5, 8'h89, 8'h6f, 8'hb7, 8'h62, 8'h0e, 8'haa, 8'h18, 8'hbe, 8'h1b,
      8'hfc, 8'h56, 8'h3e, 8'h4b, 8'hc6, 8'hd2, 8'h79, 8'h20, 8'h9a, 8'hdb, 8'hc0, 8'hfe, 8'h78, 8'hcd, 8'h5a, 8'hf4,
      8'h1f, 8'hdd, 8'ha8, 8'h33, 8'h88, 8'h07, 8'hc7, 8'h31, 8'hb1, 8'h12, 8'h10, 8'h59, 8'h27, 8'h80, 8'hec, 8'h5f,
      8'h60, 8'h51, 8'h7f, 8'ha9, 8'h19, 8'hb5, 8'h4a, 8'h0d, 8'h2d, 8'he5, 8'h7a, 8'h9f, 8'h93, 8'hc9, 8'h9c, 8'hef,
      8'ha0, 8'he0, 8'h3b, 8'h4d, 8'hae, 8'h2a, 8'hf5, 8'hb0, 8'hc8, 8'heb, 8'hbb, 8'h3c, 8'h83, 8'h53, 8'h99, 8'h61,
      8'h17, 8'h2b, 8'h04, 8'h7e, 8'hba, 8'h77, 8'hd6, 8'h26, 8'he1, 8'h69, 8'h14, 8'h63, 8'h55, 8'h21, 8'h0c, 8'h7d
   };

   function automatic logic [7:0] xtime(input logic [7:0] b);
      return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
   endfunction

   function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p;
      logic [7:0] x;
      p = '0;
      x = a;
      for (int i = 0; i < 8; i++) begin
         if (b[i]) p = p ^ x;
         x = xtime(x);
      end
      return p;
   endfunction

   function automatic logic [31:0] rot_word(input logic [31:0] w);
      return {w[23:0], w[31:24]};
   endfunction

   function automatic logic [31:0] sub_word(input logic [31:0] w);
      return {SBOX[w[31:24]], SBOX[w[23:16]], SBOX[w[15:8]], SBOX[w[7:0]]};
   endfunction

   // Undo one forward key-schedule step: round i key in, round i-1 key out.
   function automatic state_t inv_key_step(input state_t k, input logic [7:0] rc);
      logic [31:0] w0, w1, w2, w3, n0, n1, n2, n3;
      w0 = k[15:12];
      w1 = k[11:8];
      w2 = k[7:4];
      w3 = k[3:0];
      n3 = w3 ^ w2;
      n2 = w2 ^ w1;
      n1 = w1 ^ w0;
      n0 = w0 ^ sub_word(rot_word(n3)) ^ {rc, 24'h000000};
      return {n0, n1, n2, n3};
   endfunction

endpackage

// File: rtl/aes_inv_round.sv
// One combinational AES inverse round: InvShiftRows, InvSubBytes, AddRoundKey, InvMixColumns.
// Byte 15 is FIPS byte 0; FIPS byte n = 4*col + row.
module aes_inv_round
   import aes_pkg::*;
(
   input  logic [15:0][7:0] i_state,
   input  logic [15:0][7:0] i_round_key,
   input  logic             i_last,
   output logic [15:0][7:0] o_state
);

   logic [15:0][7:0] w_sub;
   logic [15:0][7:0] w_ark;
   logic [15:0][7:0] w_mix;

   for (genvar c = 0; c < 4; c++) begin : g_col
      for (genvar r = 0; r < 4; r++) begin : g_row
         localparam int DST = 15 - (4*c + r);
         localparam int SRC = 15 - (4*((c - r + 4) % 4) + r);
         localparam int A0  = 15 - (4*c + r);
         localparam int A1  = 15 - (4*c + ((r + 1) % 4));
         localparam int A2  = 15 - (4*c + ((r + 2) % 4));
         localparam int A3  = 15 - (4*c + ((r + 3) % 4));

         assign w_sub[DST] = INV_SBOX[i_state[SRC]];
         assign w_mix[DST] = gmul(w_ark[A0], 8'h0e) ^ gmul(w_ark[A1], 8'h0b)
                           ^ gmul(w_ark[A2], 8'h0d) ^ gmul(w_ark[A3], 8'h09);
      end
   end

   assign w_ark   = w_sub ^ i_round_key;
   assign o_state = i_last ? w_ark : w_mix;

endmodule

// File: rtl/aes128_decrypt_iter.sv
// Iterative AES-128 inverse cipher, one round per clock, regenerating round keys backwards
// from the round-10 key.  IDLE: accepting | RUN: rounds 9..0 | DONE: holding result.
module aes128_decrypt_iter
   import aes_pkg::*;
#(
   parameter int NR = 10
) (
   input  logic             i_clk,
   input  logic             i_rst,
   input  logic             i_in_valid,
   output logic             o_in_ready,
   input  logic [15:0][7:0] i_ct,
   input  logic [15:0][7:0] i_key_last,
   output logic             o_out_valid,
   input  logic             i_out_ready,
   output logic [15:0][7:0] o_pt,
   output logic [15:0][7:0] o_key_first
);

   if (NR != 10) begin : g_bad_nr
      $error("aes128_decrypt_iter only supports NR = 10");
   end

   fsm_t             r_fsm;
   fsm_t             w_fsm_nxt;
   logic             w_accept;
   logic             w_last;
   logic [3:0]       r_rnd;
   logic [15:0][7:0] r_state;
   logic [15:0][7:0] r_key;
   logic [15:0][7:0] r_pt;
   logic [15:0][7:0] r_key_first;
   logic [15:0][7:0] w_round_out;

   assign w_last = (r_rnd == 4'd0);

   aes_inv_round u_round (
      .i_state     (r_state),
      .i_round_key (r_key),
      .i_last      (w_last),
      .o_state     (w_round_out)
   );

   always_ff @(posedge i_clk) begin
      if (i_rst) r_fsm <= ST_IDLE;
      else       r_fsm <= w_fsm_nxt;
   end

   always_comb begin
      w_fsm_nxt   = r_fsm;
      w_accept    = 1'b0;
      o_in_ready  = 1'b0;
      o_out_valid = 1'b0;
      case (r_fsm)
         ST_IDLE: begin
            o_in_ready = 1'b1;
            if (i_in_valid) begin
               w_accept  = 1'b1;
               w_fsm_nxt = ST_RUN;
            end
         end
         ST_RUN: begin
            if (w_last) w_fsm_nxt = ST_DONE;
         end
         ST_DONE: begin
            o_out_valid = 1'b1;
            if (i_out_ready) w_fsm_nxt = ST_IDLE;
         end
         default: w_fsm_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_state     <= '0;
         r_key       <= '0;
         r_pt        <= '0;
         r_key_first <= '0;
         r_rnd       <= 4'd0;
      end else if (w_accept) begin
         r_state <= i_ct ^ i_key_last;
         r_key   <= inv_key_step(i_key_last, RCON[10]);
         r_rnd   <= 4'd9;
      end else if (r_fsm == ST_RUN) begin
         r_state <= w_round_out;
         if (!w_last) begin
            r_key <= inv_key_step(r_key, RCON[r_rnd]);
            r_rnd <= r_rnd - 4'd1;
         end else begin
            // r_key now holds the round-0 key, i.e. the original cipher key
            r_pt        <= w_round_out;
            r_key_first <= r_key;
         end
      end
   end

   assign o_pt        = r_pt;
   assign o_key_first = r_key_first;

endmodule

// File: tb/tb_aes128_decrypt_iter.sv
// Bench for aes128_decrypt_iter: FIPS-197 vectors, handshake corner cases, and a
// loopback against a forward AES-128 model built from GF(2^8) arithmetic.
`timescale 1ns/1ps
module tb_aes128_decrypt_iter;

   localparam logic [127:0] B_CT  = 128'h3925841d02dc09fbdc118597196a0b32;
   localparam logic [127:0] B_KL  = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
   localparam logic [127:0] B_PT  = 128'h3243f6a8885a308d313198a2e0370734;
   localparam logic [127:0] B_KF  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
   localparam logic [127:0] C_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
   localparam logic [127:0] C_KL  = 128'h13111d7fe3944a17f307a78b4d2b30c5;
   localparam logic [127:0] C_PT  = 128'h00112233445566778899aabbccddeeff;
   localparam logic [127:0] C_KF  = 128'h000102030405060708090a0b0c0d0e0f;

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic         in_valid = 1'b0;
   logic         in_ready;
   logic [127:0] ct = '0;
   logic [127:0] key_last = '0;
   logic         out_valid;
   logic         out_ready = 1'b0;
   logic [127:0] pt;
   logic [127:0] key_first;

   int n_vec = 0;
   int n_err = 0;

   logic [7:0] m_sbox [256];

   always #5 clk = ~clk;

   aes128_decrypt_iter dut (
      .i_clk       (clk),
      .i_rst       (rst),
      .i_in_valid  (in_valid),
      .o_in_ready  (in_ready),
      .i_ct        (ct),
      .i_key_last  (key_last),
      .o_out_valid (out_valid),
      .i_out_ready (out_ready),
      .o_pt        (pt),
      .o_key_first (key_first)
   );

   // ---------------- reference model: forward AES-128 ----------------
   function automatic logic [7:0] m_mul(input logic [7:0] a, input logic [7:0] b);
      logic [15:0] prod;
      prod = '0;
      for (int i = 0; i < 8; i++)
         if (b[i]) prod = prod ^ ({8'h00, a} << i);
      for (int i = 15; i >= 8; i--)
         if (prod[i]) prod = prod ^ (16'h011b << (i - 8));
      return prod[7:0];
   endfunction

   function automatic logic [7:0] m_rotl(input logic [7:0] b, input int k);
      logic [15:0] d;
      d = {b, b};
      return d[15-k -: 8];
   endfunction

   task automatic init_tables();
      logic [7:0] p;
      logic [7:0] inv;
      for (int x = 0; x < 256; x++) begin
         p = 8'h01;
         if (x == 0) inv = 8'h00;
         else begin
            for (int e = 0; e < 254; e++) p = m_mul(p, 8'(x));
            inv = p;
         end
         m_sbox[x] = inv ^ m_rotl(inv, 1) ^ m_rotl(inv, 2) ^ m_rotl(inv, 3) ^ m_rotl(inv, 4) ^ 8'h63;
      end
   endtask

   task automatic m_encrypt(input logic [127:0] key, input logic [127:0] ptx,
                            output logic [127:0] ctx, output logic [127:0] klast);
      logic [31:0]  w [44];
      logic [31:0]  t;
      logic [7:0]   rc;
      logic [127:0] s;
      logic [127:0] u;
      logic [7:0]   a0, a1, a2, a3;
      for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
      rc = 8'h01;
      for (int i = 4; i < 44; i++) begin
         t = w[i-1];
         if (i % 4 == 0) begin
            t = {t[23:0], t[31:24]};
            t = {m_sbox[t[31:24]], m_sbox[t[23:16]], m_sbox[t[15:8]], m_sbox[t[7:0]]};
            t[31:24] = t[31:24] ^ rc;
            rc = m_mul(rc, 8'h02);
         end
         w[i] = w[i-4] ^ t;
      end
      s = ptx ^ {w[0], w[1], w[2], w[3]};
      for (int rd = 1; rd <= 10; rd++) begin
         for (int n = 0; n < 16; n++) s[127-8*n -: 8] = m_sbox[s[127-8*n -: 8]];
         for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
               u[127-8*(4*c+r) -: 8] = s[127-8*(4*((c+r)%4)+r) -: 8];
         s = u;
         if (rd < 10) begin
            for (int c = 0; c < 4; c++) begin
               a0 = s[127-8*(4*c+0) -: 8];
               a1 = s[127-8*(4*c+1) -: 8];
               a2 = s[127-8*(4*c+2) -: 8];
               a3 = s[127-8*(4*c+3) -: 8];
               u[127-8*(4*c+0) -: 8] = m_mul(a0, 8'h02) ^ m_mul(a1, 8'h03) ^ a2 ^ a3;
               u[127-8*(4*c+1) -: 8] = a0 ^ m_mul(a1, 8'h02) ^ m_mul(a2, 8'h03) ^ a3;
               u[127-8*(4*c+2) -: 8] = a0 ^ a1 ^ m_mul(a2, 8'h02) ^ m_mul(a3, 8'h03);
               u[127-8*(4*c+3) -: 8] = m_mul(a0, 8'h03) ^ a1 ^ a2 ^ m_mul(a3, 8'h02);
            end
            s = u;
         end
         s = s ^ {w[4*rd], w[4*rd+1], w[4*rd+2], w[4*rd+3]};
      end
      ctx   = s;
      klast = {w[40], w[41], w[42], w[43]};
   endtask

   // ---------------- stimulus helpers (no checking) ----------------
   // Returns the number of clocks from the accept edge to out_valid, or -1 on timeout.
   task automatic run_block(input logic [127:0] c, input logic [127:0] k, output int lat);
      @(negedge clk);
      ct       = c;
      key_last = k;
      in_valid = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      lat = 0;
      while (out_valid !== 1'b1 && lat < 40) begin
         @(negedge clk);
         lat++;
      end
      if (out_valid !== 1'b1) lat = -1;
   endtask

   task automatic drain();
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      rst = 1'b1;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      n_vec++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL reset_in_ready: got %b expected 1", in_ready); end
      n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
      n_vec++; if (pt !== '0) begin n_err++; $display("FAIL reset_pt: got %h expected 0", pt); end
      n_vec++; if (key_first !== '0) begin n_err++; $display("FAIL reset_key_first: got %h expected 0", key_first); end
   endtask

   task automatic test_fips(input string name, input logic [127:0] c, input logic [127:0] k,
                            input logic [127:0] exp_pt, input logic [127:0] exp_kf);
      int lat;
      run_block(c, k, lat);
      // out_valid is first seen in cycle 11 when the handshake cycle is cycle 0
      n_vec++; if (lat !== 10) begin n_err++; $display("FAIL %s_latency: got %0d expected 10", name, lat); end
      n_vec++; if (pt !== exp_pt) begin n_err++; $display("FAIL %s_pt: got %h expected %h", name, pt, exp_pt); end
      n_vec++; if (key_first !== exp_kf) begin n_err++; $display("FAIL %s_key_first: got %h expected %h", name, key_first, exp_kf); end
      drain();
   endtask

   task automatic test_backpressure();
      int lat;
      out_ready = 1'b0;
      run_block(B_CT, B_KL, lat);
      n_vec++; if (lat !== 10) begin n_err++; $display("FAIL bp_latency: got %0d expected 10", lat); end
      for (int i = 0; i < 5; i++) begin
         in_valid = (i % 2 == 0);
         ct       = {$urandom, $urandom, $urandom, $urandom};
         key_last = {$urandom, $urandom, $urandom, $urandom};
         @(negedge clk);
         n_vec++; if (pt !== B_PT) begin n_err++; $display("FAIL bp_pt_hold: got %h expected %h", pt, B_PT); end
         n_vec++; if (key_first !== B_KF) begin n_err++; $display("FAIL bp_kf_hold: got %h expected %h", key_first, B_KF); end
         n_vec++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL bp_in_ready: got %b expected 0", in_ready); end
         n_vec++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL bp_out_valid: got %b expected 1", out_valid); end
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      n_vec++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL bp_idle_in_ready: got %b expected 1", in_ready); end
      n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL bp_idle_out_valid: got %b expected 0", out_valid); end
      repeat (3) @(negedge clk);
      n_vec++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL bp_not_queued_in_ready: got %b expected 1", in_ready); end
      n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL bp_not_queued_out_valid: got %b expected 0", out_valid); end
   endtask

   task automatic test_back_to_back();
      int lat;
      @(negedge clk);
      ct        = B_CT;
      key_last  = B_KL;
      in_valid  = 1'b1;
      out_ready = 1'b1;
      @(negedge clk);
      lat = 0;
      while (out_valid !== 1'b1 && lat < 40) begin @(negedge clk); lat++; end
      n_vec++; if (lat !== 10) begin n_err++; $display("FAIL b2b_first_latency: got %0d expected 10", lat); end
      n_vec++; if (pt !== B_PT) begin n_err++; $display("FAIL b2b_first_pt: got %h expected %h", pt, B_PT); end
      n_vec++; if (key_first !== B_KF) begin n_err++; $display("FAIL b2b_first_kf: got %h expected %h", key_first, B_KF); end
      ct       = C_CT;
      key_last = C_KL;
      @(negedge clk);
      n_vec++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL b2b_idle_after_handshake: got %b expected 1", in_ready); end
      @(negedge clk);
      n_vec++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL b2b_second_accept: got %b expected 0", in_ready); end
      lat = 0;
      while (out_valid !== 1'b1 && lat < 40) begin @(negedge clk); lat++; end
      in_valid = 1'b0;
      n_vec++; if (lat !== 10) begin n_err++; $display("FAIL b2b_second_latency: got %0d expected 10", lat); end
      n_vec++; if (pt !== C_PT) begin n_err++; $display("FAIL b2b_second_pt: got %h expected %h", pt, C_PT); end
      n_vec++; if (key_first !== C_KF) begin n_err++; $display("FAIL b2b_second_kf: got %h expected %h", key_first, C_KF); end
      @(negedge clk);
      out_ready = 1'b0;
      n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL b2b_final_out_valid: got %b expected 0", out_valid); end
      n_vec++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL b2b_final_in_ready: got %b expected 1", in_ready); end
   endtask

   task automatic test_reset_mid();
      int lat;
      bit seen;
      @(negedge clk);
      ct       = B_CT;
      key_last = B_KL;
      in_valid = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      repeat (4) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      n_vec++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL rstmid_in_ready: got %b expected 1", in_ready); end
      n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL rstmid_out_valid: got %b expected 0", out_valid); end
      n_vec++; if (pt !== '0) begin n_err++; $display("FAIL rstmid_pt: got %h expected 0", pt); end
      n_vec++; if (key_first !== '0) begin n_err++; $display("FAIL rstmid_key_first: got %h expected 0", key_first); end
      seen = 1'b0;
      for (int i = 0; i < 12; i++) begin
         @(negedge clk);
         if (out_valid === 1'b1) seen = 1'b1;
      end
      n_vec++; if (seen !== 1'b0) begin n_err++; $display("FAIL rstmid_aborted_output: got %b expected 0", seen); end
      run_block(B_CT, B_KL, lat);
      n_vec++; if (lat !== 10) begin n_err++; $display("FAIL rstmid_after_latency: got %0d expected 10", lat); end
      n_vec++; if (pt !== B_PT) begin n_err++; $display("FAIL rstmid_after_pt: got %h expected %h", pt, B_PT); end
      n_vec++; if (key_first !== B_KF) begin n_err++; $display("FAIL rstmid_after_kf: got %h expected %h", key_first, B_KF); end
      drain();
   endtask

   task automatic test_loopback(input int count);
      logic [127:0] key, ptx, ctx, klast;
      int lat;
      for (int i = 0; i < count; i++) begin
         key = {$urandom, $urandom, $urandom, $urandom};
         ptx = {$urandom, $urandom, $urandom, $urandom};
         m_encrypt(key, ptx, ctx, klast);
         run_block(ctx, klast, lat);
         n_vec++; if (pt !== ptx) begin n_err++; $display("FAIL loop_pt[%0d]: got %h expected %h (lat %0d)", i, pt, ptx, lat); end
         n_vec++; if (key_first !== key) begin n_err++; $display("FAIL loop_key_first[%0d]: got %h expected %h", i, key_first, key); end
         repeat ($urandom_range(0, 2)) @(negedge clk);
         drain();
      end
   endtask

   initial begin
      init_tables();
      test_reset();
      test_fips("fips_b", B_CT, B_KL, B_PT, B_KF);
      test_fips("fips_c1", C_CT, C_KL, C_PT, C_KF);
      test_backpressure();
      test_back_to_back();
      test_reset_mid();
      test_loopback(1000);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   initial begin
      #3_000_000;
      $display("FAIL watchdog: got no completion, expected finish within 3 ms");
      $fatal(1, "simulation timeout");
   end

endmodule
